// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: one valid/ready command becomes one single-beat AXI4-Lite read or write, answered in order.
// Define AXIL_MASTER_TIMEOUT_EN to add a response watchdog with DRAIN recovery for hung slaves.
module axil_cmd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int STRB_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WADDR = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] RADDR = 3'd3;
  localparam logic [2:0] RRESP = 3'd4;
  localparam logic [2:0] RSP   = 3'd5;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("axil_cmd_master: TIMEOUT_CYCLES must be at least 2");
  end

  logic [2:0] state;
  logic       aw_ok;
  logic       w_ok;

  // A write channel counts as finished once its valid is low or is being accepted this edge.
  assign aw_ok = !m_axil_awvalid || m_axil_awready;
  assign w_ok  = !m_axil_wvalid  || m_axil_wready;

  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam logic [2:0] DRAIN = 3'd6;
  localparam int         CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt;
  logic             drain_pending;
  logic             busy;
  logic             done_now;

  always_comb begin
    busy     = 1'b0;
    done_now = 1'b0;
    case (state)
      WADDR: begin busy = 1'b1; done_now = aw_ok && w_ok;   end
      WRESP: begin busy = 1'b1; done_now = m_axil_bvalid;  end
      RADDR: begin busy = 1'b1; done_now = m_axil_arready; end
      RRESP: begin busy = 1'b1; done_now = m_axil_rvalid;  end
      default: ;
    endcase
  end
`endif

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state          <= IDLE;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= 2'b00;
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
      tmo_cnt        <= '0;
      drain_pending  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            rsp_write <= cmd_write;
            if (cmd_write) begin
              m_axil_awaddr  <= cmd_addr;
              m_axil_wdata   <= cmd_wdata;
              m_axil_wstrb   <= cmd_wstrb;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state          <= WADDR;
            end else begin
              m_axil_araddr  <= cmd_addr;
              m_axil_arvalid <= 1'b1;
              state          <= RADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WADDR: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axil_bready <= 1'b1;
            state         <= WRESP;
          end
        end
        WRESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            rsp_resp      <= m_axil_bresp;
            rsp_rdata     <= '0;
            rsp_valid     <= 1'b1;
            state         <= RSP;
          end
        end
        RADDR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= RRESP;
          end
        end
        RRESP: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            rsp_rdata     <= m_axil_rdata;
            rsp_resp      <= m_axil_rresp;
            rsp_valid     <= 1'b1;
            state         <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
            if (drain_pending) begin
              m_axil_bready <= rsp_write;
              m_axil_rready <= !rsp_write;
              state         <= DRAIN;
            end else
`endif
            begin
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
`ifdef AXIL_MASTER_TIMEOUT_EN
        // The stale response owed by a timed-out slave is swallowed here.
        DRAIN: begin
          if ((m_axil_bvalid && m_axil_bready) || (m_axil_rvalid && m_axil_rready)) begin
            m_axil_bready <= 1'b0;
            m_axil_rready <= 1'b0;
            drain_pending <= 1'b0;
            cmd_ready     <= 1'b1;
            state         <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
      if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (busy) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        // Watchdog overrides the case above: abandon pending valids and report 2'b11.
        if (!done_now && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          m_axil_awvalid <= 1'b0;
          m_axil_wvalid  <= 1'b0;
          m_axil_arvalid <= 1'b0;
          m_axil_bready  <= 1'b0;
          m_axil_rready  <= 1'b0;
          rsp_resp       <= 2'b11;
          rsp_rdata      <= '0;
          rsp_valid      <= 1'b1;
          drain_pending  <= (state == WRESP) || (state == RRESP);
          state          <= RSP;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: inputs driven and outputs sampled on the falling edge.
// Compile with AXIL_MASTER_TIMEOUT_EN to add the hung-slave watchdog scenario.
`timescale 1ns/1ps
module tb_axil_cmd_master;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          axi_aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axil_awaddr;
  logic [2:0]    m_axil_awprot;
  logic          m_axil_awvalid;
  logic          m_axil_awready = 1'b0;
  logic [DW-1:0] m_axil_wdata;
  logic [SW-1:0] m_axil_wstrb;
  logic          m_axil_wvalid;
  logic          m_axil_wready = 1'b0;
  logic [1:0]    m_axil_bresp = 2'b00;
  logic          m_axil_bvalid = 1'b0;
  logic          m_axil_bready;
  logic [AW-1:0] m_axil_araddr;
  logic [2:0]    m_axil_arprot;
  logic          m_axil_arvalid;
  logic          m_axil_arready = 1'b0;
  logic [DW-1:0] m_axil_rdata = '0;
  logic [1:0]    m_axil_rresp = 2'b00;
  logic          m_axil_rvalid = 1'b0;
  logic          m_axil_rready;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  axil_cmd_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(16)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(axi_aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one command and returns in the cycle right after the accepting edge.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb);
    logic accepted;
    accepted  = 1'b0;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
    cmd_valid = 1'b1;
    for (int i = 0; i < 16 && !accepted; i++) begin
      accepted = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    checkOutput("cmd_accepted", 64'(accepted), 64'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_handshakes"},
                64'({cmd_ready, rsp_valid, m_axil_awvalid, m_axil_wvalid,
                     m_axil_bready, m_axil_arvalid, m_axil_rready}), 64'd0);
    checkOutput({tag, "_addrs"}, 64'({m_axil_awaddr, m_axil_araddr}), 64'd0);
    checkOutput({tag, "_wpayload"}, 64'({m_axil_wdata, m_axil_wstrb}), 64'd0);
    checkOutput({tag, "_rsp"}, 64'({rsp_write, rsp_resp, rsp_rdata}), 64'd0);
    checkOutput({tag, "_prot"}, 64'({m_axil_awprot, m_axil_arprot}), 64'd0);
  endtask

  task automatic consumeResponse(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput({tag, "_rsp_gone"}, 64'(rsp_valid), 64'd0);
    checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  // Zero-wait read: AR handshake at N+1, rvalid in N+2, response visible at N+3.
  task automatic runRead(input string tag, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [1:0] resp);
    m_axil_arready = 1'b1;
    applyStimulus(1'b0, addr, 32'h0, 4'h0);
    checkOutput({tag, "_arvalid"}, 64'({m_axil_arvalid, m_axil_awvalid, m_axil_wvalid}), 64'b100);
    checkOutput({tag, "_araddr"}, 64'(m_axil_araddr), 64'(addr));
    tick();
    m_axil_arready = 1'b0;
    checkOutput({tag, "_rready"}, 64'({m_axil_arvalid, m_axil_rready, rsp_valid}), 64'b010);
    m_axil_rvalid = 1'b1;
    m_axil_rdata  = data;
    m_axil_rresp  = resp;
    tick();
    m_axil_rvalid = 1'b0;
    m_axil_rdata  = 32'h0;
    checkOutput({tag, "_rsp"}, 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}),
                64'({1'b1, 1'b0, resp, data}));
    checkOutput({tag, "_rready_off"}, 64'(m_axil_rready), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed simulation still running, expected finished");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    // Reset state, then cmd_ready rises one edge after release.
    repeat (3) tick();
    checkAllZero("reset");
    axi_aresetn = 1'b1;
    tick();
    checkOutput("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);

    // Zero-wait write 0x0010 <- 0xDEADBEEF.
    m_axil_awready = 1'b1;
    m_axil_wready  = 1'b1;
    applyStimulus(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
    checkOutput("wr_valids", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, cmd_ready}), 64'b1100);
    checkOutput("wr_awaddr", 64'(m_axil_awaddr), 64'h0010);
    checkOutput("wr_wpayload", 64'({m_axil_wdata, m_axil_wstrb}), 64'h0_DEAD_BEEF_F);
    tick();
    checkOutput("wr_bready", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready, rsp_valid}), 64'b0010);
    m_axil_bvalid = 1'b1;
    m_axil_bresp  = 2'b00;
    tick();
    m_axil_bvalid = 1'b0;
    checkOutput("wr_rsp", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}), 64'({1'b1, 1'b1, 2'b00, 32'h0}));
    checkOutput("wr_no_dup", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'd0);
    consumeResponse("wr");
    m_axil_awready = 1'b0;
    m_axil_wready  = 1'b0;

    // Zero-wait read 0x0004.
    runRead("rd", 16'h0004, 32'h12345678, 2'b00);
    consumeResponse("rd");

    // Staggered write: AW accepted at N+1, W only at N+5.
    applyStimulus(1'b1, 16'h0020, 32'hA5A55A5A, 4'h3);
    checkOutput("stg_valids", 64'({m_axil_awvalid, m_axil_wvalid}), 64'b11);
    checkOutput("stg_wstrb", 64'(m_axil_wstrb), 64'h3);
    m_axil_awready = 1'b1;
    tick();
    m_axil_awready = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      checkOutput($sformatf("stg_hold_n%0d", i), 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'b010);
      tick();
    end
    checkOutput("stg_hold_n5", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'b010);
    m_axil_wready = 1'b1;
    tick();
    m_axil_wready = 1'b0;
    checkOutput("stg_bready_n6", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_bready}), 64'b001);
    m_axil_bvalid = 1'b1;
    m_axil_bresp  = 2'b10;
    tick();
    m_axil_bvalid = 1'b0;
    m_axil_bresp  = 2'b00;
    checkOutput("stg_rsp", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}), 64'({1'b1, 1'b1, 2'b10, 32'h0}));
    consumeResponse("stg");

    // Response backpressure with a second command already waiting.
    runRead("bp", 16'h0008, 32'hCAFEF00D, 2'b10);
    m_axil_awready = 1'b1;
    m_axil_wready  = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0030;
    cmd_wdata = 32'h01020304;
    cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp_hold_%0d", i), 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}),
                  64'({1'b1, 1'b0, 2'b10, 32'hCAFEF00D}));
      checkOutput($sformatf("bp_blocked_%0d", i), 64'({cmd_ready, m_axil_awvalid}), 64'b00);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("bp_after_hs", 64'({rsp_valid, cmd_ready, m_axil_awvalid}), 64'b010);
    tick();
    cmd_valid = 1'b0;
    checkOutput("bp_next_accepted", 64'({m_axil_awvalid, m_axil_wvalid, cmd_ready}), 64'b110);
    checkOutput("bp_next_awaddr", 64'(m_axil_awaddr), 64'h0030);
    tick();
    checkOutput("bp_next_bready", 64'(m_axil_bready), 64'd1);
    m_axil_bvalid = 1'b1;
    tick();
    m_axil_bvalid = 1'b0;
    checkOutput("bp_next_rsp", 64'({rsp_valid, rsp_write, rsp_resp}), 64'b1100);
    consumeResponse("bp_next");
    m_axil_awready = 1'b0;
    m_axil_wready  = 1'b0;

    // Reset pulse while waiting in RRESP abandons the read.
    m_axil_arready = 1'b1;
    applyStimulus(1'b0, 16'h000C, 32'h0, 4'h0);
    tick();
    m_axil_arready = 1'b0;
    checkOutput("mid_rready", 64'(m_axil_rready), 64'd1);
    axi_aresetn = 1'b0;
    tick();
    checkAllZero("mid_reset");
    axi_aresetn = 1'b1;
    tick();
    checkOutput("mid_cmd_ready", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("mid_no_rsp_%0d", i), 64'(rsp_valid), 64'd0);
      tick();
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    // Hung slave: AR accepted, rvalid withheld; watchdog fires at edge N+16.
    m_axil_arready = 1'b1;
    applyStimulus(1'b0, 16'h0014, 32'h0, 4'h0);
    tick();
    m_axil_arready = 1'b0;
    repeat (14) tick();
    checkOutput("tmo_not_yet", 64'({rsp_valid, m_axil_rready}), 64'b01);
    tick();
    checkOutput("tmo_rsp", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}), 64'({1'b1, 1'b0, 2'b11, 32'h0}));
    checkOutput("tmo_rready_off", 64'(m_axil_rready), 64'd0);
    consumeResponseDrain();
    repeat (3) tick();
    checkOutput("tmo_drain_hold", 64'({cmd_ready, m_axil_rready}), 64'b01);
    m_axil_rvalid = 1'b1;
    m_axil_rdata  = 32'hBADBAD00;
    tick();
    m_axil_rvalid = 1'b0;
    m_axil_rdata  = 32'h0;
    checkOutput("tmo_drained", 64'({rsp_valid, m_axil_rready, cmd_ready}), 64'b001);
    runRead("tmo_after", 16'h0018, 32'h600DF00D, 2'b00);
    consumeResponse("tmo_after");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  task automatic consumeResponseDrain();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("tmo_drain_entry", 64'({rsp_valid, cmd_ready, m_axil_rready}), 64'b001);
  endtask
`endif

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

AXI4-Lite initiator that turns a simple valid/ready command stream into single AXI4-Lite read or write transactions, and returns each transaction's response on a valid/ready response stream. It drives the same 32-bit AXI4-Lite slave ports our debug-bridge and register blocks expose, so on-chip sequencers (ICAP control, LED/test logic) can access those blocks without a host. Only one transaction is outstanding at a time, and responses come back in command order.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width.
- ADDR_WIDTH, 16, AXI byte-address width.
- STRB_WIDTH, 4, write-strobe width (DATA_WIDTH/8).
- TIMEOUT_CYCLES, 1024, response watchdog limit; used only when the timeout macro is defined; must be ≥2.

Ports:
- axi_aclk  in  1  clock; all logic on rising edge.
- axi_aresetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored on reads.
- cmd_wstrb  in  STRB_WIDTH  write strobes; ignored on reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  AXI BRESP/RRESP; 2'b11 on timeout.
- m_axil_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master channel, widths from the parameters. awprot and arprot are tied to 3'b000.

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RRESP, RSP, plus DRAIN when timeout is compiled in.
- IDLE: cmd_ready = 1. On accept, the block latches addr/wdata/wstrb/write. A write goes to WADDR with awvalid = wvalid = 1. A read goes to RADDR with arvalid = 1.
- WADDR: awvalid drops on the awready handshake and wvalid drops on the wready handshake, each independently. The block goes to WRESP when both handshakes are done, including when both complete in the same cycle. AW and W handshakes may complete in either order.
- WRESP: bready = 1. On bvalid, the block latches bresp into rsp_resp, sets rsp_rdata = 0 and goes to RSP.
- RADDR: arvalid is held until arready, then the block goes to RRESP.
- RRESP: rready = 1. On rvalid, the block latches rdata/rresp and goes to RSP.
- RSP: rsp_valid = 1, with fields stable until rsp_ready. On handshake the block goes to IDLE.
- AXI valid signals, once asserted, never drop before their handshake, and their payloads stay stable.
- All outputs are registered.
- Reset value of every output is 0: cmd_ready, rsp_valid, all m_axil valid/ready, all addr/data/strb/resp outputs, and rsp_write. The FSM resets to IDLE, so cmd_ready = 1 in the first cycle after reset is released.
- Reset mid-transaction abandons the transaction immediately. No response is generated.

## Timing
- The command is accepted at edge N. aw/w/arvalid are high from cycle N+1.
- With a zero-wait slave (ready already high, response the cycle after the handshake), rsp_valid rises at N+3 for both reads and writes. Minimum command-to-command spacing is 4 cycles when rsp_ready is held high.
- cmd_ready is high only in IDLE, so there is no command pipelining.
- bready is high only in WRESP and rready only in RRESP. Responses arriving in other states are not accepted by this block.

## Configuration
- AXIL_MASTER_TIMEOUT_EN defined:
  - A counter clears on entering WADDR/RADDR and counts every cycle spent in WADDR, WRESP, RADDR and RRESP.
  - When it reaches TIMEOUT_CYCLES-1 without completion, the block deasserts all pending aw/w/arvalid. This is a documented deliberate deviation, for hung slaves only.
  - It then loads rsp_resp = 2'b11 and rsp_rdata = 0 and goes to RSP.
  - If the address phase had completed, the block goes from RSP to DRAIN instead of IDLE. In DRAIN, bready/rready is held at 1 and cmd_ready = 0 until the stale response arrives, which is discarded. The block then goes to IDLE.
- Undefined: no counter and no DRAIN state. The block waits indefinitely.

## Test plan
- Write 0x0010 ← 0xDEADBEEF, strb 4'hF, zero-wait slave, bresp 2'b00 → one AW and one W handshake with matching payload; rsp_valid at N+3 with rsp_write = 1, rsp_resp = 2'b00, rsp_rdata = 0.
- Read 0x0004, slave returns 0x12345678 with rresp 2'b00 → rsp_rdata = 0x12345678, rsp_write = 0, rsp_resp = 2'b00.
- Staggered write: awready high at N+1 and wready high only at N+5 → awvalid drops after N+1, wvalid holds until N+5, bready rises at N+6, no duplicate AW.
- Response backpressure: rsp_ready low for 10 cycles after a read with rresp 2'b10 → rsp_valid and fields stable for all 10 cycles; cmd_valid held high is not accepted until the cycle after the rsp handshake.
- Reset asserted (axi_aresetn = 0) for 1 cycle while in RRESP → next cycle all outputs are 0. After release, cmd_ready = 1 and no rsp_valid appears.
- With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16: slave accepts AR but never asserts rvalid → rsp_resp = 2'b11 after 16 cycles. A late rvalid 5 cycles later is absorbed in DRAIN with no second rsp_valid. A following read then completes normally.
